merge_layers: RTL and testbench
===============================

MERGE_LAYERS -- requirements
Module: merge_layers

Interface
REQ-001 Parameter COLOR_W, default 8, bits per colour channel.
REQ-002 Parameter NUM_SP, default 4, number of sprite layers (1..8).
REQ-003 Parameter PIX_PER_BUF, default 16, pixels per line bank.
REQ-004 Parameter KEY_RGB, default 24'hFF00FF, transparent colour {R,G,B} (with COLOR_W=8).
REQ-005 clk  in  1  single clock; all logic is rising-edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 in_valid  in  1  input pixel present.
REQ-008 in_ready  out  1  block accepts a pixel this cycle.
REQ-009 R_bg, G_bg, B_bg  in  COLOR_W each  background pixel.
REQ-010 R_sp, G_sp, B_sp  in  NUM_SP*COLOR_W each  sprite pixels; sprite i at [i*COLOR_W +: COLOR_W].
REQ-011 sp_en  in  NUM_SP  per-sprite enable.
REQ-012 rd_done  in  1  one-cycle pulse from the VGA side: read bank consumed.
REQ-013 R_out, G_out, B_out  out  PIX_PER_BUF*COLOR_W each  read-bank contents; pixel p at [p*COLOR_W +: COLOR_W].
REQ-014 line_valid  out  1  read bank holds a completed line.
REQ-015 bank_sel  out  1  0: read bank A / write bank B; 1: the reverse.
REQ-016 collision  out  NUM_SP  per-sprite collision flags for the line in the read bank.

Function
REQ-017 Sprite i SHALL be opaque when sp_en[i]=1 and its {R,G,B} differs from KEY_RGB.
REQ-018 The merged pixel SHALL be the lowest-index opaque sprite, else the background; there is no blending.
REQ-019 Accept: in_valid & in_ready at a rising edge; the merged pixel SHALL be written to the write bank at index pix_cnt on that edge.
REQ-020 pix_cnt SHALL increment per accept and wrap to 0 after PIX_PER_BUF-1.
REQ-021 States: FILL (in_ready=1) and WAIT_SWAP (in_ready=0).
REQ-022 FILL -> WAIT_SWAP on the accept of pixel PIX_PER_BUF-1.
REQ-023 WAIT_SWAP -> FILL on rd_done=1: bank_sel toggles, line_valid <= 1, pix_cnt <= 0, and the write collision accumulator is copied to collision then cleared, all on the same edge.
REQ-024 rd_done SHALL be ignored in FILL, including the same cycle as the last-pixel accept; the swap needs a later rd_done.
REQ-025 in_valid in WAIT_SWAP SHALL be ignored, with no write.
REQ-026 Collision accumulator bit i SHALL be set (sticky) on an accepted pixel where sprite i is opaque and at least one other sprite is opaque.
REQ-027 R_out/G_out/B_out/collision SHALL change only at a swap or reset, never during a fill.
REQ-028 The write bank SHALL NOT be cleared at swap; stale pixels are overwritten as the line fills.
REQ-029 All outputs SHALL be registered or derived from state only, with no input-to-output combinational path except none on in_ready.
REQ-030 Throughput: one pixel per cycle in FILL; line latency is PIX_PER_BUF accepts plus the wait for rd_done.

Reset
REQ-031 reset=1 SHALL set: state FILL, pix_cnt 0, bank_sel 0, line_valid 0, collision 0, collision accumulator 0, both banks all-zero (so R_out/G_out/B_out = 0).
REQ-032 Reset SHALL override accepts and rd_done in the same cycle; a partially filled line is discarded.
REQ-033 in_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (defaults: COLOR_W=8, NUM_SP=4, PIX_PER_BUF=16)
REQ-034 Priority/transparency: bg=20/50/40, sp0=FF/00/FF, sp1=17/17/17, sp_en=4'b0011, 16 accepts, then rd_done -> every pixel of R_out/G_out/B_out = 17/17/17; collision=0; bank_sel=1; line_valid=1.
REQ-035 Collision: one accept with sp0=30/54/41, sp2=87/32/50, sp_en=4'b0101, then swap -> collision=4'b0101 and the pixel = 30/54/41.
REQ-036 Back-pressure: after 16 accepts with in_valid held high and no rd_done for 5 cycles -> in_ready=0, pix_cnt stays 0, and the write bank is unchanged.
REQ-037 Same-cycle rd_done: rd_done asserted together with the 16th accept -> no swap and line_valid stays 0; rd_done one cycle later -> swap.
REQ-038 Mid-line reset: reset after 7 accepts -> all outputs at reset values; the next 16 accepts plus rd_done form a fresh line starting at index 0.
REQ-039 Ping-pong: two lines (all 20/50/40, then all 87/32/50) with rd_done after each -> outputs show 20/50/40 with bank_sel=1, then 87/32/50 with bank_sel=0.

Source files
------------

// File: rtl/merge_layers.sv
// Sprite-over-background line merger with ping-pong line banks.
// One bank fills with merged pixels while the other is presented to the VGA side.
module merge_layers #(
    parameter int                   COLOR_W     = 8,
    parameter int                   NUM_SP      = 4,
    parameter int                   PIX_PER_BUF = 16,
    parameter logic [3*COLOR_W-1:0] KEY_RGB     = 24'hFF00FF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [COLOR_W-1:0]              R_bg,
    input  logic [COLOR_W-1:0]              G_bg,
    input  logic [COLOR_W-1:0]              B_bg,
    input  logic [NUM_SP*COLOR_W-1:0]       R_sp,
    input  logic [NUM_SP*COLOR_W-1:0]       G_sp,
    input  logic [NUM_SP*COLOR_W-1:0]       B_sp,
    input  logic [NUM_SP-1:0]               sp_en,
    input  logic                            rd_done,
    output logic [PIX_PER_BUF*COLOR_W-1:0]  R_out,
    output logic [PIX_PER_BUF*COLOR_W-1:0]  G_out,
    output logic [PIX_PER_BUF*COLOR_W-1:0]  B_out,
    output logic                            line_valid,
    output logic                            bank_sel,
    output logic [NUM_SP-1:0]               collision
);

    localparam int CNT_W = (PIX_PER_BUF > 1) ? $clog2(PIX_PER_BUF) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIX_PER_BUF - 1);

    typedef enum logic [0:0] {
        S_FILL      = 1'b0,
        S_WAIT_SWAP = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [CNT_W-1:0]     r_pix_cnt;
    logic                 r_bank_sel;
    logic                 r_line_valid;
    logic [NUM_SP-1:0]    r_collision;
    logic [NUM_SP-1:0]    r_coll_acc;

    // Index 0 is bank A, index 1 is bank B.
    logic [COLOR_W-1:0]   r_bank_r [0:1][0:PIX_PER_BUF-1];
    logic [COLOR_W-1:0]   r_bank_g [0:1][0:PIX_PER_BUF-1];
    logic [COLOR_W-1:0]   r_bank_b [0:1][0:PIX_PER_BUF-1];

    logic [NUM_SP-1:0]    w_opaque;
    logic                 w_multi;
    logic [NUM_SP-1:0]    w_coll_new;
    logic [COLOR_W-1:0]   w_mrg_r;
    logic [COLOR_W-1:0]   w_mrg_g;
    logic [COLOR_W-1:0]   w_mrg_b;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_swap;
    logic                 w_wr_bank;

    assign w_accept  = in_valid & in_ready;
    assign w_last    = (r_pix_cnt == LAST_IDX);
    assign w_swap    = (r_state == S_WAIT_SWAP) & rd_done;
    assign w_wr_bank = ~r_bank_sel;

    // Per-sprite opacity: enabled and not the colour key.
    always_comb begin
        w_opaque = '0;
        for (int i = 0; i < NUM_SP; i++) begin
            if (sp_en[i] && ({R_sp[i*COLOR_W +: COLOR_W],
                              G_sp[i*COLOR_W +: COLOR_W],
                              B_sp[i*COLOR_W +: COLOR_W]} != KEY_RGB)) begin
                w_opaque[i] = 1'b1;
            end else begin
                w_opaque[i] = 1'b0;
            end
        end
    end

    // Walk from the highest index down so the lowest opaque sprite wins.
    always_comb begin
        w_mrg_r = R_bg;
        w_mrg_g = G_bg;
        w_mrg_b = B_bg;
        for (int i = NUM_SP - 1; i >= 0; i--) begin
            w_mrg_r = w_opaque[i] ? R_sp[i*COLOR_W +: COLOR_W] : w_mrg_r;
            w_mrg_g = w_opaque[i] ? G_sp[i*COLOR_W +: COLOR_W] : w_mrg_g;
            w_mrg_b = w_opaque[i] ? B_sp[i*COLOR_W +: COLOR_W] : w_mrg_b;
        end
    end

    // Clearing the lowest set bit leaves something only when two or more sprites overlap.
    assign w_multi    = |(w_opaque & (w_opaque - NUM_SP'(1)));
    assign w_coll_new = w_multi ? w_opaque : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; rd_done during FILL is deliberately ignored.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FILL: begin
                if (w_accept && w_last) begin
                    w_next_state = S_WAIT_SWAP;
                end else begin
                    w_next_state = S_FILL;
                end
            end
            S_WAIT_SWAP: begin
                if (rd_done) begin
                    w_next_state = S_FILL;
                end else begin
                    w_next_state = S_WAIT_SWAP;
                end
            end
            default: w_next_state = S_FILL;
        endcase
    end

    // Output decode from state.
    always_comb begin
        in_ready = 1'b0;
        case (r_state)
            S_FILL:      in_ready = 1'b1;
            S_WAIT_SWAP: in_ready = 1'b0;
            default:     in_ready = 1'b0;
        endcase
    end

    // Counter, bank select, line status and collision tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt    <= '0;
            r_bank_sel   <= 1'b0;
            r_line_valid <= 1'b0;
            r_collision  <= '0;
            r_coll_acc   <= '0;
        end else if (w_swap) begin
            r_pix_cnt    <= '0;
            r_bank_sel   <= ~r_bank_sel;
            r_line_valid <= 1'b1;
            r_collision  <= r_coll_acc;
            r_coll_acc   <= '0;
        end else if (w_accept) begin
            r_pix_cnt    <= w_last ? '0 : r_pix_cnt + CNT_W'(1);
            r_coll_acc   <= r_coll_acc | w_coll_new;
        end
    end

    // Line banks: only the write bank is touched, and never cleared on swap.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < PIX_PER_BUF; p++) begin
                    r_bank_r[b][p] <= '0;
                    r_bank_g[b][p] <= '0;
                    r_bank_b[b][p] <= '0;
                end
            end
        end else if (w_accept) begin
            r_bank_r[w_wr_bank][r_pix_cnt] <= w_mrg_r;
            r_bank_g[w_wr_bank][r_pix_cnt] <= w_mrg_g;
            r_bank_b[w_wr_bank][r_pix_cnt] <= w_mrg_b;
        end
    end

    for (genvar p = 0; p < PIX_PER_BUF; p++) begin : g_out
        assign R_out[p*COLOR_W +: COLOR_W] = r_bank_r[r_bank_sel][p];
        assign G_out[p*COLOR_W +: COLOR_W] = r_bank_g[r_bank_sel][p];
        assign B_out[p*COLOR_W +: COLOR_W] = r_bank_b[r_bank_sel][p];
    end

    assign line_valid = r_line_valid;
    assign bank_sel   = r_bank_sel;
    assign collision  = r_collision;

endmodule

// File: tb/tb_merge_layers.sv
// Directed self-checking bench for merge_layers at default parameters.
module tb_merge_layers;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   R_bg, G_bg, B_bg;
    logic [31:0]  R_sp, G_sp, B_sp;
    logic [3:0]   sp_en;
    logic         rd_done;
    logic [127:0] R_out, G_out, B_out;
    logic         line_valid;
    logic         bank_sel;
    logic [3:0]   collision;

    int n_vec;
    int n_miss;

    merge_layers dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .R_bg       (R_bg),
        .G_bg       (G_bg),
        .B_bg       (B_bg),
        .R_sp       (R_sp),
        .G_sp       (G_sp),
        .B_sp       (B_sp),
        .sp_en      (sp_en),
        .rd_done    (rd_done),
        .R_out      (R_out),
        .G_out      (G_out),
        .B_out      (B_out),
        .line_valid (line_valid),
        .bank_sel   (bank_sel),
        .collision  (collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pixels below index k hold a, the rest hold b.
    function automatic logic [127:0] line_of(input logic [7:0] a, input logic [7:0] b, input int k);
        logic [127:0] v;
        for (int p = 0; p < 16; p++) begin
            v[p*8 +: 8] = (p < k) ? a : b;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic push(input int n);
        in_valid = 1'b1;
        repeat (n) tick();
        in_valid = 1'b0;
    endtask

    task automatic swap();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
    endtask

    task automatic set_bg(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        R_bg = r;
        G_bg = g;
        B_bg = b;
    endtask

    task automatic set_sp(input int i, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        R_sp[i*8 +: 8] = r;
        G_sp[i*8 +: 8] = g;
        B_sp[i*8 +: 8] = b;
    endtask

    task automatic check_line(input string tag, input logic [7:0] r0, input logic [7:0] g0,
                              input logic [7:0] b0, input logic [7:0] r1, input logic [7:0] g1,
                              input logic [7:0] b1, input int k);
        check_vec({tag, "_R"}, R_out, line_of(r0, r1, k));
        check_vec({tag, "_G"}, G_out, line_of(g0, g1, k));
        check_vec({tag, "_B"}, B_out, line_of(b0, b1, k));
    endtask

    task automatic check_reset_state(input string tag);
        check_vec({tag, "_R"}, R_out, 128'h0);
        check_vec({tag, "_G"}, G_out, 128'h0);
        check_vec({tag, "_B"}, B_out, 128'h0);
        check_vec({tag, "_lv"}, line_valid, 128'h0);
        check_vec({tag, "_bs"}, bank_sel, 128'h0);
        check_vec({tag, "_col"}, collision, 128'h0);
        check_vec({tag, "_rdy"}, in_ready, 128'h1);
    endtask

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        rd_done  = 1'b0;
        sp_en    = 4'b0000;
        R_sp     = 32'h0;
        G_sp     = 32'h0;
        B_sp     = 32'h0;
        set_bg(8'h00, 8'h00, 8'h00);
        do_reset();
        check_reset_state("rst0");

        // Sprite 0 keyed out, sprite 1 shows through; only one opaque -> no collision.
        set_bg(8'h20, 8'h50, 8'h40);
        set_sp(0, 8'hFF, 8'h00, 8'hFF);
        set_sp(1, 8'h17, 8'h17, 8'h17);
        sp_en = 4'b0011;
        push(16);
        check_vec("prio_rdy_wait", in_ready, 128'h0);
        check_vec("prio_lv_before", line_valid, 128'h0);
        swap();
        check_line("prio", 8'h17, 8'h17, 8'h17, 8'h17, 8'h17, 8'h17, 16);
        check_vec("prio_col", collision, 128'h0);
        check_vec("prio_bs", bank_sel, 128'h1);
        check_vec("prio_lv", line_valid, 128'h1);
        check_vec("prio_rdy", in_ready, 128'h1);

        // Sprites 0 and 2 overlap on pixel 0 only; flag is sticky for the line.
        set_sp(0, 8'h30, 8'h54, 8'h41);
        set_sp(2, 8'h87, 8'h32, 8'h50);
        sp_en = 4'b0101;
        push(1);
        sp_en = 4'b0000;
        set_bg(8'h11, 8'h22, 8'h33);
        push(15);
        swap();
        check_line("coll", 8'h30, 8'h54, 8'h41, 8'h11, 8'h22, 8'h33, 1);
        check_vec("coll_flags", collision, 128'h5);
        check_vec("coll_bs", bank_sel, 128'h0);

        // Outputs stay frozen mid-fill; then back-pressure ignores in_valid.
        set_bg(8'h20, 8'h50, 8'h40);
        push(8);
        check_line("frozen", 8'h30, 8'h54, 8'h41, 8'h11, 8'h22, 8'h33, 1);
        check_vec("frozen_col", collision, 128'h5);
        push(8);
        set_bg(8'h99, 8'h99, 8'h99);
        push(5);
        check_vec("bp_rdy", in_ready, 128'h0);
        check_vec("bp_bs", bank_sel, 128'h0);
        swap();
        check_line("bp", 8'h20, 8'h50, 8'h40, 8'h20, 8'h50, 8'h40, 16);
        check_vec("bp_col_clr", collision, 128'h0);
        check_vec("bp_bs2", bank_sel, 128'h1);
        // Next line must start at index 0 despite the ignored extra valids.
        set_bg(8'h55, 8'h66, 8'h77);
        push(1);
        set_bg(8'h87, 8'h32, 8'h50);
        push(15);
        swap();
        check_line("bp_next", 8'h55, 8'h66, 8'h77, 8'h87, 8'h32, 8'h50, 1);
        check_vec("bp_next_bs", bank_sel, 128'h0);

        // rd_done coinciding with the last accept must not swap.
        do_reset();
        check_reset_state("rst1");
        set_bg(8'h87, 8'h32, 8'h50);
        push(15);
        in_valid = 1'b1;
        rd_done  = 1'b1;
        tick();
        in_valid = 1'b0;
        rd_done  = 1'b0;
        tick();
        check_vec("same_lv", line_valid, 128'h0);
        check_vec("same_bs", bank_sel, 128'h0);
        check_vec("same_rdy", in_ready, 128'h0);
        check_vec("same_R", R_out, 128'h0);
        swap();
        check_vec("late_lv", line_valid, 128'h1);
        check_vec("late_bs", bank_sel, 128'h1);
        check_line("late", 8'h87, 8'h32, 8'h50, 8'h87, 8'h32, 8'h50, 16);

        // Partial line discarded by reset, asserted while still pushing.
        set_bg(8'h11, 8'h22, 8'h33);
        push(7);
        in_valid = 1'b1;
        do_reset();
        in_valid = 1'b0;
        check_reset_state("rst_mid");
        set_bg(8'h55, 8'h66, 8'h77);
        push(1);
        set_bg(8'h20, 8'h50, 8'h40);
        push(15);
        swap();
        check_line("fresh", 8'h55, 8'h66, 8'h77, 8'h20, 8'h50, 8'h40, 1);
        check_vec("fresh_bs", bank_sel, 128'h1);

        // Ping-pong across both banks.
        do_reset();
        set_bg(8'h20, 8'h50, 8'h40);
        push(16);
        swap();
        check_line("pp1", 8'h20, 8'h50, 8'h40, 8'h20, 8'h50, 8'h40, 16);
        check_vec("pp1_bs", bank_sel, 128'h1);
        set_bg(8'h87, 8'h32, 8'h50);
        push(16);
        swap();
        check_line("pp2", 8'h87, 8'h32, 8'h50, 8'h87, 8'h32, 8'h50, 16);
        check_vec("pp2_bs", bank_sel, 128'h0);
        check_vec("pp2_lv", line_valid, 128'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
